// File: rtl/traffic_pkg.sv
// Shared phase codes and lamp decode for the intersection phase scheduler.
package traffic_pkg;

    localparam int PHASE_W = 3;

    typedef enum logic [PHASE_W-1:0] {
        MAJ_G = 3'd0,
        MAJ_Y = 3'd1,
        MIN_G = 3'd2,
        MIN_Y = 3'd3,
        WALK  = 3'd4
    } phase_t;

    typedef struct packed {
        logic major_green;
        logic major_yellow;
        logic minor_green;
        logic minor_yellow;
    } lamps_t;

    function automatic lamps_t lamp_decode(phase_t p);
        lamps_t l;
        l = '0;
        case (p)
            MAJ_G:   l.major_green  = 1'b1;
            MAJ_Y:   l.major_yellow = 1'b1;
            MIN_G:   l.minor_green  = 1'b1;
            MIN_Y:   l.minor_yellow = 1'b1;
            default: l = '0;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// Sensor/lamp bundle of the phase scheduler; slave side is the scheduler itself.
// Pedestrian signals exist only when PED_WALK_EN is defined.
interface traffic_phase_scheduler_if
    import traffic_pkg::*;
#(
    parameter int N_MINOR = 4
);
    logic [N_MINOR-1:0] car;
    logic               major_green;
    logic               major_yellow;
    logic [N_MINOR-1:0] minor_grant;
    logic               minor_yellow;
    logic [PHASE_W-1:0] phase;
    logic [N_MINOR-1:0] pending;
`ifdef PED_WALK_EN
    logic               ped_req;
    logic               walk;
`endif

    modport master (
`ifdef PED_WALK_EN
        output ped_req,
        input  walk,
`endif
        output car,
        input  major_green, major_yellow, minor_grant, minor_yellow, phase, pending
    );

    modport slave (
`ifdef PED_WALK_EN
        input  ped_req,
        output walk,
`endif
        input  car,
        output major_green, major_yellow, minor_grant, minor_yellow, phase, pending
    );

endinterface

// File: rtl/traffic_phase_scheduler_rr_arbiter.sv
// Combinational N-way round-robin pick: first set req bit strictly after ptr, wrapping.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);
    logic          found;
    logic [IW-1:0] sel;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < N; k++) begin
            sel = IW'((int'(ptr) + 1 + k) % N);
            if (!found && req[sel]) begin
                found    = 1'b1;
                gnt[sel] = 1'b1;
                idx      = sel;
            end
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Major road / round-robin minor approach phase sequencer with clearance timing.
// Optional pedestrian all-red walk phase is built when PED_WALK_EN is defined.
//
//   state | meaning
//   MAJ_G | major green, held until min time elapsed and a request is waiting
//   MAJ_Y | major yellow; on exit the round-robin winner is granted
//   MIN_G | granted minor approach green
//   MIN_Y | granted minor approach yellow
//   WALK  | all red, walk lamp on (PED_WALK_EN only)
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int N_MINOR     = 4,
    parameter int GREEN_MIN   = 8,
    parameter int GREEN_MINOR = 6,
    parameter int YELLOW      = 2,
    parameter int WALK_CYC    = 5,
    parameter int TW          = 8
) (
    input logic                      clk,
    input logic                      reset,
    traffic_phase_scheduler_if.slave bus
);
    localparam int IW = $clog2(N_MINOR);

    phase_t             phase_q, phase_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [N_MINOR-1:0] pending_q, pending_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      grant_q, grant_d;
    logic [N_MINOR-1:0] clr;
    logic [N_MINOR-1:0] win_onehot;
    logic [IW-1:0]      win_idx;
    logic               tdone;
    logic               take_grant;
    lamps_t             lamps;
`ifdef PED_WALK_EN
    logic               ped_q, ped_d;
`endif

    function automatic logic [TW-1:0] load_of(phase_t p);
        case (p)
            MAJ_G:        return TW'(GREEN_MIN - 1);
            MAJ_Y, MIN_Y: return TW'(YELLOW - 1);
            MIN_G:        return TW'(GREEN_MINOR - 1);
            default:      return TW'(WALK_CYC - 1);
        endcase
    endfunction

    rr_arbiter #(.N(N_MINOR)) u_arb (
        .req (pending_q),
        .ptr (ptr_q),
        .gnt (win_onehot),
        .idx (win_idx)
    );

    assign tdone = (timer_q == '0);

    always_comb begin
        phase_d    = phase_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        clr        = '0;
        take_grant = 1'b0;
        case (phase_q)
            MAJ_G: begin
`ifdef PED_WALK_EN
                if (tdone && ((|pending_q) || ped_q)) phase_d = MAJ_Y;
`else
                if (tdone && (|pending_q)) phase_d = MAJ_Y;
`endif
            end
            MAJ_Y: begin
                if (tdone) begin
`ifdef PED_WALK_EN
                    if (ped_q && (pending_q == '0)) phase_d = WALK;
                    else                            take_grant = 1'b1;
`else
                    take_grant = 1'b1;
`endif
                end
            end
            MIN_G: if (tdone) phase_d = MIN_Y;
            MIN_Y: begin
                if (tdone) begin
`ifdef PED_WALK_EN
                    phase_d = ped_q ? WALK : MAJ_G;
`else
                    phase_d = MAJ_G;
`endif
                end
            end
`ifdef PED_WALK_EN
            WALK:  if (tdone) phase_d = MAJ_G;
`endif
            default: phase_d = MAJ_G;
        endcase

        // Sticky requests guarantee a winner whenever take_grant fires.
        if (take_grant) begin
            phase_d = MIN_G;
            grant_d = win_idx;
            ptr_d   = win_idx;
            clr     = win_onehot;
        end

        if (phase_d != phase_q) timer_d = load_of(phase_d);
        else if (tdone)         timer_d = timer_q;
        else                    timer_d = timer_q - 1'b1;

        pending_d = (pending_q | bus.car) & ~clr;
`ifdef PED_WALK_EN
        ped_d = (phase_d == WALK && phase_q != WALK) ? 1'b0 : (ped_q | bus.ped_req);
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q   <= MAJ_G;
            timer_q   <= TW'(GREEN_MIN - 1);
            pending_q <= '0;
            ptr_q     <= IW'(N_MINOR - 1);
            grant_q   <= '0;
`ifdef PED_WALK_EN
            ped_q     <= 1'b0;
`endif
        end else begin
            phase_q   <= phase_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
`ifdef PED_WALK_EN
            ped_q     <= ped_d;
`endif
        end
    end

    assign lamps            = lamp_decode(phase_q);
    assign bus.major_green  = lamps.major_green;
    assign bus.major_yellow = lamps.major_yellow;
    assign bus.minor_yellow = lamps.minor_yellow;
    assign bus.minor_grant  = lamps.minor_green ? (N_MINOR'(1) << grant_q) : '0;
    assign bus.phase        = phase_q;
    assign bus.pending      = pending_q;
`ifdef PED_WALK_EN
    assign bus.walk         = (phase_q == WALK);
`endif

endmodule
